// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, queue
// entry layout, default queue depth and an address-alignment helper.
package fetch_unit_pkg;

    localparam int unsigned QDEPTH_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,  // request driven, response will be queued
        ST_HOLD    = 2'd1,  // queue full, no request
        ST_DISCARD = 2'd2   // request driven, response will be dropped
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// Small circular prefetch queue. Flush has priority over push and pop;
// push and pop may coincide, including when full.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = QDEPTH_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  fetch_entry_t                     push_entry,
    input  logic                             pop,
    input  logic                             flush,
    output fetch_entry_t                     head,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(DEPTH+1)-1:0]       count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t          mem_q [DEPTH];
    fetch_entry_t          mem_d [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next pointers, occupancy and storage contents.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Queue state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: storage is reset too because the head entry drives inst/inst_pc, which must read zero out of reset.
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory handshake, redirect
// handling with response discard, and a prefetch queue toward decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = QDEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   discard_addr_q, discard_addr_d;

    logic          q_push, q_pop, q_flush, q_full, q_empty;
    logic [CW-1:0] q_count;
    logic [CW:0]   occ_after_push;
    fetch_entry_t  q_head;

    assign inst_valid     = !q_empty;
    assign inst           = q_head.inst;
    assign inst_pc        = q_head.pc;
    assign q_pop          = inst_valid && inst_ready;
    assign occ_after_push = {1'b0, q_count} + {{CW{1'b0}}, 1'b1} - {{CW{1'b0}}, q_pop};

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (q_push),
        .push_entry ('{pc: imem_addr, inst: imem_rdata}),
        .pop        (q_pop),
        .flush      (q_flush),
        .head       (q_head),
        .full       (q_full),
        .empty      (q_empty),
        .count      (q_count)
    );

    // Next-state, fetch address and memory request generation.
    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        discard_addr_d = discard_addr_q;
        q_push         = 1'b0;
        q_flush        = 1'b0;
        imem_req       = 1'b0;
        imem_addr      = fetch_pc_q;
        unique case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (redirect) begin
                    q_flush    = 1'b1;
                    fetch_pc_d = word_align(redirect_pc);
                    if (imem_ack) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d        = ST_DISCARD;
                        discard_addr_d = fetch_pc_q;
                    end
                end else if (imem_ack) begin
                    q_push     = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = (occ_after_push == (CW+1)'(QDEPTH)) ? ST_HOLD : ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    q_flush    = 1'b1;
                    fetch_pc_d = word_align(redirect_pc);
                    state_d    = ST_FETCH;
                end else if (!q_full || q_pop) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                // The old request stays on the bus until it completes; its data is never queued.
                imem_req  = 1'b1;
                imem_addr = discard_addr_q;
                if (redirect) begin
                    q_flush    = 1'b1;
                    fetch_pc_d = word_align(redirect_pc);
                end
                if (imem_ack) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
        if (rst) begin
            imem_req = 1'b0;
        end
    end

    // FSM and fetch address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_FETCH;
            fetch_pc_q     <= RESET_PC;
            discard_addr_q <= RESET_PC;
        end else begin
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            discard_addr_q <= discard_addr_d;
        end
    end

endmodule
